rv_dmem_responder: RTL and testbench
====================================

# rv_dmem_responder

Data-memory responder for the uRV core: the slave end of the core's data-memory interface, attached directly to the core's `dm_*` ports. It accepts one load or store request at a time, services it from an internal byte-lane-writable word RAM after a configurable number of wait states, and signals completion with one-cycle done pulses. It is used as the tightly-coupled data RAM in simulation and in small FPGA builds.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words (16 KB at default).
- `WAIT_STATES`, default 2: extra cycles between accept and done; range 0..15; used only with `RV_DMEM_WAIT_EN`.
- `INIT_FILE`, default "": hex file loaded into the RAM by `$readmemh` when non-empty.
- `clk_i`  in  1  single clock; everything is on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `dm_addr_i`  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word.
- `dm_data_s_i`  in  32  store data, already lane-aligned.
- `dm_data_select_i`  in  4  byte-lane enables for stores; bit n enables byte n.
- `dm_store_i`  in  1  store request.
- `dm_load_i`  in  1  load request.
- `dm_ready_o`  out  1  responder can accept a request this cycle.
- `dm_data_l_o`  out  32  load data, full word.
- `dm_load_done_o`  out  1  one-cycle pulse: load complete, `dm_data_l_o` valid.
- `dm_store_done_o`  out  1  one-cycle pulse: store committed.

## Operation
- **Accept.** A request is accepted on a rising edge where `(dm_load_i || dm_store_i) && dm_ready_o`. Address, data and select are captured at accept; they are ignored afterwards.
- **Both requests asserted.** This is a protocol violation. The store is performed, the load is dropped, and only `dm_store_done_o` pulses.
- **Address decode.**
  - Bits [1:0] are ignored; no misalignment fault is raised.
  - Bits above ADDR_WIDTH+1 are ignored, so addresses alias (wrap) modulo the RAM size.
- **Stores.**
  - Only the enabled byte lanes are written.
  - `dm_data_select_i` = 0 writes nothing, but `dm_store_done_o` still pulses.
- **Loads.** Loads return the full word. `dm_data_select_i` is ignored because lane extraction is the core's job. `dm_data_l_o` holds its value until the next load completes.
- **State machine** (`RV_DMEM_WAIT_EN` defined): IDLE, WAIT, DONE.
  - IDLE: `dm_ready_o` = 1. On accept, go to WAIT with counter = WAIT_STATES-1, or go straight to DONE if WAIT_STATES = 0.
  - WAIT: `dm_ready_o` = 0. Decrement the counter; at 0, go to DONE.
  - DONE: `dm_ready_o` = 0. On this edge the RAM write commits (store) or the RAM word is registered into `dm_data_l_o` (load). The matching done pulse is high during the cycle after that edge. Return to IDLE.
- **Reset values.** State IDLE, `dm_ready_o` = 1 (0 while `rst_n_i` is low), `dm_load_done_o` = 0, `dm_store_done_o` = 0, `dm_data_l_o` = 0, counter = 0. RAM contents are not reset.
- **Reset mid-transaction.** The pending transaction is dropped with no done pulse. With `RV_DMEM_WAIT_EN`, a pending store is not committed.

## Timing
- **With `RV_DMEM_WAIT_EN`:**
  - Accept on edge N; the done pulse is high during cycle N+1+WAIT_STATES.
  - `dm_ready_o` returns high in the cycle after the done pulse.
  - Minimum issue interval is WAIT_STATES+2 cycles.
- **Without `RV_DMEM_WAIT_EN`:**
  - `dm_ready_o` is constant 1.
  - Store: written at edge N. Load: RAM registered to `dm_data_l_o` at edge N.
  - The done pulse is high in cycle N+1.
  - Back-to-back requests are accepted every cycle. A load accepted one cycle after a store to the same word returns the new data.
- **Read-after-write.** A load accepted after a store's done pulse always returns the stored bytes merged with the unmodified lanes.
- **Pulse exclusivity.** Done pulses are exactly one cycle wide and never overlap each other.

## Configuration
- `RV_DMEM_WAIT_EN` defined: the IDLE/WAIT/DONE FSM, the wait counter and the WAIT_STATES parameter are in effect.
- `RV_DMEM_WAIT_EN` undefined: single-cycle pipelined responder, no FSM, WAIT_STATES ignored.

## Structure
- **In `rv_defs.v`:**
  - State encodings `RV_DMEM_ST_IDLE`, `RV_DMEM_ST_WAIT`, `RV_DMEM_ST_DONE` (2 bits).
  - Counter width constant `RV_DMEM_WAIT_W` = 4.
- **Sub-module `rv_dmem_ram`:**
  - 2^ADDR_WIDTH x 32 synchronous RAM with 4 byte-write enables, one write/read port and registered read.
  - Handles `INIT_FILE` loading.
  - The top level holds the FSM, the request capture registers and the done generation.

## Test plan
- **Basic store/load, WAIT_STATES=2, macro on.** Store 0xDEADBEEF to 0x100 with select 4'hF, then load 0x100.
  - `dm_store_done_o` pulses 3 cycles after accept.
  - `dm_load_done_o` pulses 3 cycles after its accept with `dm_data_l_o` = 0xDEADBEEF.
  - `dm_ready_o` is low for exactly 3 cycles per transaction.
- **Byte lanes.** Store 0x11223344 to 0x40 (select F), then store 0xAABBCCDD with select 4'b0101, then load 0x40 → 0x11BB33DD. A store with select 0 changes nothing but still pulses `dm_store_done_o`.
- **Aliasing with ADDR_WIDTH=12.** Store 0x5A5A5A5A to 0x4000, then load 0x0000 → 0x5A5A5A5A. Loading 0x0003 returns the same word.
- **Reset mid-operation.** Accept a store of 0xCAFEF00D to 0x80, assert `rst_n_i` low during WAIT, release, then load 0x80.
  - No store done pulse appears after reset.
  - All outputs hold their reset values during reset.
  - The load returns the old value.
- **Macro off, back-to-back.** Store 0x12345678 to 0x20 at cycle N, load 0x20 at N+1, load 0x24 at N+2.
  - Done pulses at N+1, N+2, N+3.
  - Load data 0x12345678 at N+2.
  - `dm_ready_o` stays 1 throughout.
- **Simultaneous `dm_load_i` and `dm_store_i`.** Store 0x0BADC0DE to 0x10 → only `dm_store_done_o` pulses; a subsequent load returns 0x0BADC0DE.

Source files
------------

// File: rtl/rv_dmem_responder_pkg.sv
// Shared definitions for the uRV data-memory responder: FSM state encodings
// and the wait-state counter width.
package rv_dmem_responder_pkg;

  localparam int RV_DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    RV_DMEM_ST_IDLE = 2'd0,
    RV_DMEM_ST_WAIT = 2'd1,
    RV_DMEM_ST_DONE = 2'd2
  } rv_dmem_state_e;

endpackage

// File: rtl/rv_dmem_ram.sv
// Single-port 2^ADDR_WIDTH x 32 word RAM with per-byte write enables and a
// registered read port.
module rv_dmem_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // The read register is the load-data output, so it resets and holds between loads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rv_dmem_responder.sv
// Data-memory slave for the uRV dm_* port. Define RV_DMEM_WAIT_EN for the
// IDLE/WAIT/DONE responder with WAIT_STATES extra cycles; otherwise single-cycle.
module rv_dmem_responder
  import rv_dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o
);

  localparam logic [RV_DMEM_WAIT_W-1:0] WAIT_CFG = RV_DMEM_WAIT_W'(WAIT_STATES);

  logic [ADDR_WIDTH-1:0] live_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [3:0]            ram_we;
  logic                  ram_re;
  logic                  unused_addr;

  assign live_addr   = dm_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr = ^{dm_addr_i[31:ADDR_WIDTH+2], dm_addr_i[1:0]};

`ifdef RV_DMEM_WAIT_EN
  rv_dmem_state_e              state_q, state_d;
  logic [RV_DMEM_WAIT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [31:0]                 data_q;
  logic [3:0]                  sel_q;
  logic                        store_q;
  logic                        accept;
  logic                        commit;
  logic                        use_live;
  logic                        cur_store;

  assign dm_ready_o      = rst_n_i && (state_q == RV_DMEM_ST_IDLE);
  assign accept          = (dm_load_i || dm_store_i) && dm_ready_o;
  assign dm_store_done_o = (state_q == RV_DMEM_ST_DONE) && store_q;
  assign dm_load_done_o  = (state_q == RV_DMEM_ST_DONE) && !store_q;

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the live request drives the RAM; otherwise the captured copy does.
  assign use_live  = (state_q == RV_DMEM_ST_IDLE);
  assign cur_store = use_live ? dm_store_i : store_q;
  assign ram_addr  = use_live ? live_addr : addr_q;
  assign ram_wdata = use_live ? dm_data_s_i : data_q;
  assign ram_we    = (commit && cur_store) ? (use_live ? dm_data_select_i : sel_q) : 4'b0000;
  assign ram_re    = commit && !cur_store;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RV_DMEM_ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= live_addr;
        data_q  <= dm_data_s_i;
        sel_q   <= dm_data_select_i;
        store_q <= dm_store_i;
      end
    end
  end

  // The RAM commits on the edge that enters DONE; DONE is the done-pulse cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      RV_DMEM_ST_IDLE: begin
        if (accept) begin
          if (WAIT_CFG == '0) begin
            commit  = 1'b1;
            state_d = RV_DMEM_ST_DONE;
          end else begin
            cnt_d   = WAIT_CFG - 1'b1;
            state_d = RV_DMEM_ST_WAIT;
          end
        end
      end
      RV_DMEM_ST_WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RV_DMEM_ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RV_DMEM_ST_DONE: state_d = RV_DMEM_ST_IDLE;
      default:         state_d = RV_DMEM_ST_IDLE;
    endcase
  end
`else
  logic load_done_q;
  logic store_done_q;
  logic unused_cfg;

  assign unused_cfg      = ^WAIT_CFG;
  assign dm_ready_o      = 1'b1;
  assign ram_addr        = live_addr;
  assign ram_wdata       = dm_data_s_i;
  assign ram_we          = dm_store_i ? dm_data_select_i : 4'b0000;
  assign ram_re          = dm_load_i && !dm_store_i;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;

  // A store wins over a simultaneous load, so at most one pulse per request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      load_done_q  <= ram_re;
      store_done_q <= dm_store_i;
    end
  end
`endif

  rv_dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .addr    (ram_addr),
    .we      (ram_we),
    .re      (ram_re),
    .wdata   (ram_wdata),
    .rdata   (dm_data_l_o)
  );

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Scoreboard bench for rv_dmem_responder: directed and random requests are
// predicted by a word-array model; a monitor checks every done pulse and cycle.
module tb_rv_dmem_responder;

  localparam int AW = 12;
  localparam int WS = 2;
`ifdef RV_DMEM_WAIT_EN
  localparam int LAT = WS;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    bit          isStore;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk_i            = 1'b0;
  logic        rst_n_i          = 1'b0;
  logic [31:0] dm_addr_i        = '0;
  logic [31:0] dm_data_s_i      = '0;
  logic [3:0]  dm_data_select_i = '0;
  logic        dm_store_i       = 1'b0;
  logic        dm_load_i        = 1'b0;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;

  exp_t        expQ[$];
  logic [31:0] memModel [int];
  logic [31:0] lastLoad = '0;
  exp_t        monE;
  int          cyc    = 0;
  int          checks = 0;
  int          passes = 0;

  always #5 clk_i = ~clk_i;

  rv_dmem_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS),
    .INIT_FILE   ("")
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_store_i       (dm_store_i),
    .dm_load_i        (dm_load_i),
    .dm_ready_o       (dm_ready_o),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o)
  );

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic reportMiss(input string name, input string what);
    checks++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference model: a word array indexed modulo the RAM size, byte-merged on stores.
  function automatic exp_t modelAccess(input bit st, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] sel);
    exp_t        e;
    int          idx;
    logic [31:0] word;
    idx  = int'((addr >> 2) % (32'd1 << AW));
    word = memModel.exists(idx) ? memModel[idx] : 'x;
    e.isStore = st;
    e.due     = 0;
    e.data    = word;
    if (st) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) word[8*b +: 8] = data[8*b +: 8];
      memModel[idx] = word;
      e.data = '0;
    end
    return e;
  endfunction

  task automatic applyStimulus(input bit ld, input bit st, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sel);
    exp_t e;
    int   waitCnt;
    waitCnt = 0;
    @(negedge clk_i);
    while (!dm_ready_o && waitCnt < 64) begin
      @(negedge clk_i);
      waitCnt++;
    end
    if (!dm_ready_o) begin
      reportMiss("ready_timeout", "dm_ready_o stayed 0 for 64 cycles, required 1");
      return;
    end
    dm_addr_i        = addr;
    dm_data_s_i      = data;
    dm_data_select_i = sel;
    dm_load_i        = ld;
    dm_store_i       = st;
    e     = modelAccess(st, addr, data, sel);
    e.due = cyc + 1 + LAT;
    expQ.push_back(e);
    @(posedge clk_i);
    #1;
    dm_load_i        = 1'b0;
    dm_store_i       = 1'b0;
    dm_addr_i        = $urandom();
    dm_data_s_i      = $urandom();
    dm_data_select_i = 4'($urandom());
  endtask

  task automatic checkResetValues();
`ifdef RV_DMEM_WAIT_EN
    checkOutput("reset_ready", 32'(dm_ready_o), 32'd0);
`else
    checkOutput("reset_ready", 32'(dm_ready_o), 32'd1);
`endif
    checkOutput("reset_load_done", 32'(dm_load_done_o), 32'd0);
    checkOutput("reset_store_done", 32'(dm_store_done_o), 32'd0);
    checkOutput("reset_load_data", dm_data_l_o, 32'd0);
  endtask

  task automatic resetMidTransaction();
`ifdef RV_DMEM_WAIT_EN
    logic [31:0] saved;
    saved = memModel[32];
`endif
    applyStimulus(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    expQ.delete();
`ifdef RV_DMEM_WAIT_EN
    memModel[32] = saved;
`endif
    repeat (2) begin
      #1;
      checkResetValues();
      @(negedge clk_i);
    end
    rst_n_i  = 1'b1;
    lastLoad = '0;
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks latency, data and ready.
  always @(posedge clk_i) begin
    #1;
    if (rst_n_i) begin
`ifdef RV_DMEM_WAIT_EN
      checkOutput("ready", 32'(dm_ready_o), 32'(expQ.size() == 0));
`else
      checkOutput("ready", 32'(dm_ready_o), 32'd1);
`endif
      checkOutput("pulse_overlap", 32'(dm_load_done_o & dm_store_done_o), 32'd0);
      if (dm_load_done_o || dm_store_done_o) begin
        if (expQ.size() == 0) begin
          reportMiss("unexpected_done", "done pulse with no request outstanding, required none");
        end else begin
          monE = expQ.pop_front();
          checkOutput("done_kind_store", 32'(dm_store_done_o), 32'(monE.isStore));
          checkOutput("done_cycle", 32'(cyc), 32'(monE.due));
          if (!monE.isStore) begin
            checkOutput("load_data", dm_data_l_o, monE.data);
            lastLoad = monE.data;
          end
        end
      end else begin
        checkOutput("load_hold", dm_data_l_o, lastLoad);
        if (expQ.size() > 0 && cyc > expQ[0].due) begin
          reportMiss("missing_done", $sformatf("no done pulse by cycle %0d, required at %0d", cyc, expQ[0].due));
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #12;
    checkResetValues();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int w = 0; w < 16; w++) applyStimulus(1'b0, 1'b1, 32'(w * 4), $urandom(), 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h40, $urandom(), 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h600DCAFE, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h100, $urandom(), 4'hF);

    applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);

    applyStimulus(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

    applyStimulus(1'b0, 1'b1, 32'h4000, 32'h5A5A5A5A, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h0000, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h0003, 32'h0, 4'h0);

    applyStimulus(1'b1, 1'b1, 32'h10, 32'h0BADC0DE, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

    applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);

    resetMidTransaction();
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);

    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk_i);
      applyStimulus((r == 0) || (r >= 5), (r <= 4), a, $urandom(), 4'($urandom()));
    end

    for (int i = 0; i < 64 && expQ.size() != 0; i++) @(negedge clk_i);
    if (expQ.size() != 0) reportMiss("drain_timeout", $sformatf("%0d responses outstanding, required 0", expQ.size()));
    @(negedge clk_i);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
